// File: rtl/nvlink_tx_flit_scheduler_if.sv
// Request/flit handshake bundle for the NVLink TX flit scheduler.
//   req_valid/req_payload/req_coh/req_ready : per-VC request channel (VC i at [i*96 +: 96], [i*8 +: 8])
//   credit_return                           : per-VC credit pulse from the link partner
//   flit_out/flit_valid/flit_ready          : registered flit channel toward PCS/TX
// slave = scheduler side, master = requester/PCS side.
interface nvlink_tx_flit_scheduler_if #(
    parameter int NUM_VC = 4
);
    logic [NUM_VC-1:0]    req_valid;
    logic [NUM_VC*96-1:0] req_payload;
    logic [NUM_VC*8-1:0]  req_coh;
    logic [NUM_VC-1:0]    req_ready;
    logic [NUM_VC-1:0]    credit_return;
    logic [127:0]         flit_out;
    logic                 flit_valid;
    logic                 flit_ready;

    modport slave (
        input  req_valid, req_payload, req_coh, credit_return, flit_ready,
        output req_ready, flit_out, flit_valid
    );

    modport master (
        output req_valid, req_payload, req_coh, credit_return, flit_ready,
        input  req_ready, flit_out, flit_valid
    );
endinterface

// File: rtl/nvlink_tx_flit_scheduler.sv
// Credit-based round-robin scheduler sharing the NVLink TX framing path
// between NUM_VC virtual channels. Stamps a 24-bit sequence ID (first flit
// after reset = 1) and emits {coh, seq, payload} through a registered
// valid/ready stage.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : request channel, credit returns, flit channel
//   credits_out     : per-VC credit count, VC i at [i*CRED_WIDTH +: CRED_WIDTH]
//   seq_next        : seq ID the next granted flit will carry
//   credit_overflow : sticky, set when a return arrives at a full counter

// Per-VC credit counter. drop flags a return that cannot be absorbed.
module nvlink_tx_vc_credit #(
    parameter int CRED_WIDTH   = 6,
    parameter int INIT_CREDITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  grant,
    input  logic                  ret,
    output logic [CRED_WIDTH-1:0] cnt,
    output logic                  drop
);
    localparam logic [CRED_WIDTH-1:0] INIT = CRED_WIDTH'(INIT_CREDITS);
    localparam logic [CRED_WIDTH-1:0] ONE  = CRED_WIDTH'(1);

    assign drop = ret && !grant && (cnt == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= INIT;
        else if (grant && !ret)
            cnt <= cnt - ONE;
        else if (ret && !grant && (cnt != INIT))
            cnt <= cnt + ONE;
    end
endmodule

module nvlink_tx_flit_scheduler #(
    parameter int NUM_VC       = 4,
    parameter int SEQ_WIDTH    = 24,
    parameter int CRED_WIDTH   = 6,
    parameter int INIT_CREDITS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nvlink_tx_flit_scheduler_if.slave    bus,
    output logic [NUM_VC*CRED_WIDTH-1:0] credits_out,
    output logic [SEQ_WIDTH-1:0]         seq_next,
    output logic                         credit_overflow
);
    localparam int IDX_W = $clog2(NUM_VC);

    logic [NUM_VC-1:0]                 elig;
    logic [NUM_VC-1:0]                 gnt;
    logic [NUM_VC-1:0]                 drop;
    logic [NUM_VC-1:0][CRED_WIDTH-1:0] cred;
    logic [IDX_W-1:0]                  last_grant;
    logic [IDX_W-1:0]                  gnt_idx;
    logic                              gnt_any;
    logic                              can_load;
    logic [SEQ_WIDTH-1:0]              seq_q;
    logic [127:0]                      flit_q;
    logic                              fv_q;
    logic                              ovf_q;

    assign can_load        = !fv_q || bus.flit_ready;
    assign bus.req_ready   = gnt;
    assign bus.flit_out    = flit_q;
    assign bus.flit_valid  = fv_q;
    assign seq_next        = seq_q;
    assign credit_overflow = ovf_q;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        nvlink_tx_vc_credit #(
            .CRED_WIDTH  (CRED_WIDTH),
            .INIT_CREDITS(INIT_CREDITS)
        ) u_cred (
            .clk  (clk),
            .rst_n(rst_n),
            .grant(gnt[i]),
            .ret  (bus.credit_return[i]),
            .cnt  (cred[i]),
            .drop (drop[i])
        );
        // A VC with no credits is simply skipped; the pointer never waits on it.
        assign elig[i] = bus.req_valid[i] && (cred[i] != '0);
        assign credits_out[i*CRED_WIDTH +: CRED_WIDTH] = cred[i];
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_c;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = 0;
        idx_c   = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            idx   = (int'(last_grant) + k) % NUM_VC;
            idx_c = IDX_W'(idx);
            if (can_load && !gnt_any && elig[idx_c]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_c;
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q       <= 1'b0;
            flit_q     <= '0;
            seq_q      <= SEQ_WIDTH'(1);
            last_grant <= IDX_W'(NUM_VC - 1);   // VC0 wins first
            ovf_q      <= 1'b0;
        end else begin
            if (gnt_any) begin
                flit_q     <= {bus.req_coh[int'(gnt_idx)*8 +: 8], seq_q,
                               bus.req_payload[int'(gnt_idx)*96 +: 96]};
                fv_q       <= 1'b1;
                seq_q      <= seq_q + SEQ_WIDTH'(1);
                last_grant <= gnt_idx;
            end else if (bus.flit_ready) begin
                fv_q <= 1'b0;
            end
            if (|drop)
                ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nvlink_tx_flit_scheduler.sv
module tb_nvlink_tx_flit_scheduler;
    localparam int NV = 4;
    localparam int CW = 6;
    localparam int IC = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NV*CW-1:0] credits_out;
    logic [23:0]     seq_next;
    logic            credit_overflow;

    nvlink_tx_flit_scheduler_if #(.NUM_VC(NV)) bus();

    nvlink_tx_flit_scheduler #(
        .NUM_VC(NV), .SEQ_WIDTH(24), .CRED_WIDTH(CW), .INIT_CREDITS(IC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .credits_out    (credits_out),
        .seq_next       (seq_next),
        .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model state: plain integers/arrays.
    int           m_cred[NV];
    int           m_last;
    logic [23:0]  m_seq;
    logic         m_fv;
    logic [127:0] m_flit;
    logic         m_ovf;
    int           m_g;

    typedef struct {
        logic [3:0] vld;
        logic       frdy;
        logic [3:0] rdy;
        logic       fv;
        int         seq;
        int         vc;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) m_cred[i] = IC;
        m_last = NV - 1;
        m_seq  = 24'd1;
        m_fv   = 1'b0;
        m_flit = '0;
        m_ovf  = 1'b0;
    endtask

    function automatic int model_pick();
        int idx;
        if (m_fv && !bus.flit_ready) return -1;
        for (int k = 1; k <= NV; k++) begin
            idx = (m_last + k) % NV;
            if (bus.req_valid[idx] && m_cred[idx] > 0) return idx;
        end
        return -1;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic fr);
        bus.req_valid     = v;
        bus.credit_return = r;
        bus.flit_ready    = fr;
    endtask

    task automatic fixed_payload();
        for (int i = 0; i < NV; i++) begin
            bus.req_payload[i*96 +: 96] = 96'hA5 + 96'(i) * 96'h100;
            bus.req_coh[i*8 +: 8]       = 8'h3C + 8'(i);
        end
    endtask

    // Evaluate the model's grant and compare all outputs at the negedge.
    task automatic half_a();
        logic [NV-1:0] er;
        m_g = model_pick();
        @(negedge clk);
        er = '0;
        if (m_g >= 0) er[m_g] = 1'b1;
        chk("req_ready", bus.req_ready, er);
        chk("flit_valid", bus.flit_valid, m_fv);
        if (m_fv) chk("flit_out", bus.flit_out, m_flit);
        for (int i = 0; i < NV; i++)
            chk($sformatf("credits[%0d]", i), credits_out[i*CW +: CW], CW'(m_cred[i]));
        chk("seq_next", seq_next, m_seq);
        chk("credit_overflow", credit_overflow, m_ovf);
    endtask

    // Advance the model across the active edge.
    task automatic half_b();
        logic gi, ri;
        @(posedge clk);
        if (m_g >= 0) begin
            m_flit = {bus.req_coh[m_g*8 +: 8], m_seq, bus.req_payload[m_g*96 +: 96]};
            m_fv   = 1'b1;
            m_seq  = m_seq + 24'd1;
            m_last = m_g;
        end else if (bus.flit_ready) begin
            m_fv = 1'b0;
        end
        for (int i = 0; i < NV; i++) begin
            gi = (m_g == i);
            ri = bus.credit_return[i];
            if (gi && !ri) m_cred[i]--;
            else if (ri && !gi) begin
                if (m_cred[i] == IC) m_ovf = 1'b1;
                else m_cred[i]++;
            end
        end
        #1;
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 1'b1);
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_flit_valid", bus.flit_valid, 1'b0);
        chk("rst_flit_out", bus.flit_out, 128'd0);
        chk("rst_req_ready", bus.req_ready, 4'b0);
        for (int i = 0; i < NV; i++)
            chk("rst_credits", credits_out[i*CW +: CW], CW'(IC));
        chk("rst_seq_next", seq_next, 24'd1);
        chk("rst_overflow", credit_overflow, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] held;

        tbl[0] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 0, 0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 0};
        tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 1};
        tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 2};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4, 3};
        tbl[5] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 5, 0};
        tbl[6] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 5, 0};
        tbl[7] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 5, 0};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 6, 2};
        tbl[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0};

        fixed_payload();
        do_reset();

        // Directed table: first grant, RR order, hold, skip of invalid VCs, drain.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vld, 4'b0, tbl[i].frdy);
            half_a();
            chk("tbl_rdy", bus.req_ready, tbl[i].rdy);
            chk("tbl_fv", bus.flit_valid, tbl[i].fv);
            if (tbl[i].fv) begin
                chk("tbl_seq", bus.flit_out[119:96], 24'(tbl[i].seq));
                chk("tbl_payload", bus.flit_out[95:0], 96'hA5 + 96'(tbl[i].vc) * 96'h100);
                chk("tbl_coh", bus.flit_out[127:120], 8'h3C + 8'(tbl[i].vc));
            end
            half_b();
        end

        // Backpressure: hold 5 cycles, then reload on the same edge ready rises.
        drive(4'b1111, 4'b0, 1'b1);
        tick();
        held = m_flit;
        drive(4'b1111, 4'b0, 1'b0);
        repeat (5) begin
            half_a();
            chk("hold_rdy", bus.req_ready, 4'b0);
            chk("hold_flit", bus.flit_out, held);
            half_b();
        end
        drive(4'b1111, 4'b0, 1'b1);
        tick();
        half_a();
        chk("reload_seq", bus.flit_out[119:96], held[119:96] + 24'd1);
        half_b();

        // Credit exhaustion and return on VC2.
        do_reset();
        drive(4'b0100, 4'b0, 1'b1);
        repeat (16) tick();
        half_a();
        chk("vc2_cred0", credits_out[2*CW +: CW], CW'(0));
        chk("vc2_blocked", bus.req_ready, 4'b0);
        half_b();
        drive(4'b0100, 4'b0100, 1'b1);
        tick();
        drive(4'b0100, 4'b0, 1'b1);
        half_a();
        chk("vc2_regrant", bus.req_ready, 4'b0100);
        half_b();
        drive(4'b0, 4'b0, 1'b1);
        tick();

        // Overflow at full count, sticky; grant plus return nets to zero.
        do_reset();
        drive(4'b0, 4'b0010, 1'b1);
        tick();
        drive(4'b0, 4'b0, 1'b1);
        half_a();
        chk("ovf_set", credit_overflow, 1'b1);
        chk("ovf_cred", credits_out[1*CW +: CW], CW'(16));
        half_b();
        repeat (4) tick();
        drive(4'b0010, 4'b0, 1'b1);
        tick();
        drive(4'b0010, 4'b0010, 1'b1);
        tick();
        drive(4'b0, 4'b0, 1'b1);
        half_a();
        chk("gnt_ret_cred", credits_out[1*CW +: CW], CW'(15));
        chk("ovf_sticky", credit_overflow, 1'b1);
        half_b();

        // Sequence wrap via backdoor load while idle.
        repeat (2) tick();
        force dut.seq_q = 24'hFFFFFF;
        m_seq = 24'hFFFFFF;
        tick();
        release dut.seq_q;
        drive(4'b0001, 4'b0, 1'b1);
        tick();
        half_a();
        chk("wrap_seq_ff", bus.flit_out[119:96], 24'hFFFFFF);
        half_b();
        half_a();
        chk("wrap_seq_0", bus.flit_out[119:96], 24'h000000);
        half_b();

        // Reset mid-stream.
        drive(4'b1111, 4'b0, 1'b1);
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_fv", bus.flit_valid, 1'b0);
        chk("midrst_seq", seq_next, 24'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        half_a();
        chk("postrst_seq", bus.flit_out[119:96], 24'd1);
        half_b();

        // Randomized traffic against the model.
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < NV; i++) begin
                bus.req_payload[i*96 +: 96] = {$urandom, $urandom, $urandom};
                bus.req_coh[i*8 +: 8]       = 8'($urandom);
            end
            drive(4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0,
                  ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/nvlink_tx_flit_scheduler.md
Name: nvlink_tx_flit_scheduler

Overview:
Credit-based round-robin scheduler that shares the single NVLink TX framing path between NUM_VC virtual-channel requesters. It selects one eligible VC per grant and stamps the 24-bit sequence ID. It then emits a 128-bit flit {coh[7:0], seq[23:0], payload[95:0]} through a registered valid/ready output toward PCS/TX. Its sequence numbering matches the RX decoder's in-order check: the first flit after reset carries seq 1, and each later flit carries the previous seq + 1.

Parameters:
NUM_VC, 4, number of virtual-channel requesters (2..8)
SEQ_WIDTH, 24, sequence ID width; must equal 24 for the 128-bit flit format
CRED_WIDTH, 6, width of each per-VC credit counter
INIT_CREDITS, 16, credits loaded per VC at reset; also the per-VC maximum (must be < 2^CRED_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_VC  per-VC flit request
req_payload  input  NUM_VC*96  per-VC payload; VC i occupies bits [i*96 +: 96]
req_coh  input  NUM_VC*8  per-VC coherence bits; VC i occupies [i*8 +: 8]
req_ready  output  NUM_VC  one-hot grant; VC i's request is consumed on a cycle where req_valid[i] && req_ready[i]
credit_return  input  NUM_VC  per-VC pulse; each asserted bit returns one credit
flit_out  output  128  {coh, seq, payload}
flit_valid  output  1  flit_out holds a valid flit
flit_ready  input  1  downstream accepts flit_out
credits_out  output  NUM_VC*CRED_WIDTH  current credit count per VC
seq_next  output  SEQ_WIDTH  seq ID for the next granted flit
credit_overflow  output  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): flit_valid=0, flit_out=0, req_ready=0, every credit counter = INIT_CREDITS, seq_next=1, RR pointer = VC0 highest priority, credit_overflow=0.
- Eligibility: VC i is eligible when req_valid[i]=1 and credits[i]>0.
- can_load = !flit_valid || flit_ready.
- Grant is combinational. When can_load=1 and at least one VC is eligible, exactly one bit of req_ready is set: the first eligible VC searching upward from (last_grant+1) mod NUM_VC. Otherwise req_ready=0.
- req_ready never asserts for a non-eligible VC. req_ready depends only on registered state, req_valid and flit_ready.
- On a grant to VC g (at the clock edge):
  - flit_out <= {req_coh[g], seq_next, req_payload[g]}
  - flit_valid <= 1
  - seq_next <= seq_next + 1, modulo 2^SEQ_WIDTH (all-ones wraps to 0)
  - last_grant <= g
  - credits[g] decrements by 1
- Latency: the flit is visible on flit_out one cycle after the grant cycle.
- Output hold: while flit_valid && !flit_ready, flit_out and flit_valid stay stable and no grant is issued.
- Drain and reload: when flit_valid && flit_ready and no VC is eligible, flit_valid <= 0 next cycle. When a VC is eligible, the new flit loads in that same edge, giving back-to-back flits (one flit per cycle throughput).
- Credit update per VC, per cycle:
  - grant and credit_return together: count unchanged
  - credit_return only: +1, saturating at INIT_CREDITS; a return arriving at INIT_CREDITS is dropped and sets credit_overflow (sticky until reset)
  - grant only: -1
  - A VC with 0 credits is skipped. The RR pointer does not wait on it.
- Starvation bound: an eligible VC is granted within NUM_VC grants.
- Reset mid-operation: an in-flight flit is discarded (flit_valid=0 immediately); seq restarts at 1 and credits reload.

Test Plan:
1. Reset, then VC0 valid with payload 96'hA5, coh 8'h3C, flit_ready=1 -> req_ready=4'b0001 at once; next cycle flit_out={8'h3C, 24'd1, 96'hA5} with flit_valid=1; credits_out[VC0]=15.
2. All 4 VCs valid continuously, flit_ready=1 -> grant order 0,1,2,3,0,1,...; seq 1,2,3,... on consecutive cycles with no bubbles.
3. flit_ready=0 for 5 cycles while flit_valid=1 -> flit_out stable and req_ready=0 throughout; when flit_ready rises, the next flit loads on that same edge.
4. VC2 alone, 16 grants with no credit_return -> credits_out[VC2]=0 and req_ready[2] stays 0. A credit_return[2] pulse -> VC2 is granted the next cycle.
5. credit_return[1] with VC1 at 16 credits -> count stays 16 and credit_overflow=1, held until reset. Grant plus return in the same cycle -> count unchanged.
6. Force seq_next to 24'hFFFFFF via a long run or backdoor -> flit carries seq FFFFFF, the following flit carries seq 0. Assert rst_n low mid-stream -> flit_valid=0 immediately, and the first flit after release carries seq 1.
